// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_responder_pkg;

    localparam int WORD_W = 64;
    localparam int MASK_W = WORD_W / 8;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (master) and dmem_responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    // A request transfers on a rising edge with req_valid & req_ready; a response
    // transfers with rsp_valid & rsp_ready. Valid, once high, holds with stable
    // payload until its transfer edge; ready may change freely.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: one byte-masked synchronous write port, one combinational read port.
// Contents are deliberately never reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 512,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency and
// out-of-range error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                DEPTH     = 512,
    parameter int                LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_responder_if.slave     bus,
    output state_e              dbg_state
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH) << 3;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;
    logic              live_q;

    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_addr_bits;

    // Offset is taken at full width so addresses below BASE_ADDR cannot wrap into range.
    assign offset           = bus.req_addr - BASE_ADDR;
    assign in_range         = (bus.req_addr >= BASE_ADDR) && (offset < SPAN);
    assign idx              = offset[IDX_W+2:3];
    assign unused_addr_bits = ^{offset[ADDR_W-1:IDX_W+3], offset[2:0]};

    assign bus.req_ready = live_q && (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign mem_we        = accept && bus.req_we && in_range;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx),
        .wdata (bus.req_wdata),
        .wmask (bus.req_wmask),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (CNT_LOAD == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // The counter reaches zero on the same edge that enters RESP.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                err_q   <= !in_range;
                rdata_q <= (in_range && !bus.req_we) ? mem_rdata : '0;
            end
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  state_e dbg_state, dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  dmem_responder_if bus();
  dmem_responder_if bus1();

  dmem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg_state1)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks (LATENCY=2 instance)
  task automatic send(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask);
    @(negedge clk);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    bus.req_valid = 1'b1;
    check("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Latency = index of the first rising edge after acceptance at which rsp_valid is high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp(input string tag, input logic exp_err);
    logic [63:0] e;
    e = exp_q.pop_front();
    check({tag, "_rdata"}, bus.rsp_rdata, e);
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_idle_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     input logic [63:0] exp_data, input logic exp_err);
    int lat;
    exp_q.push_back(exp_data);
    send(we, addr, wdata, wmask);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd2);
    finish_rsp(tag, exp_err);
  endtask

  initial begin
    int lat;
    int vcount;
    int k;
    logic [9:0] rdy_pat, vld_pat;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wmask = '0; bus.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.rsp_ready = 1'b1;

    // reset state
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // full store / load
    txn("st_full", 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
    txn("ld_full", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);

    // partial store, low address bits ignored, mask ignored on loads
    txn("st_half", 1'b1, 64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0);
    txn("ld_half", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0);
    txn("ld_low_bits", 1'b0, 64'h8000_000C, 64'd0, 8'h3C, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // empty mask is a no-op that still responds
    txn("st_nomask", 1'b1, 64'h8000_0008, 64'h0, 8'h00, 64'd0, 1'b0);
    txn("ld_nomask", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // range boundaries; an out-of-range store must not alias onto word 0
    txn("st_word0", 1'b1, 64'h8000_0000, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 64'd0, 1'b0);
    txn("st_last", 1'b1, 64'h8000_0FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 1'b0);
    txn("ld_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
    txn("ld_above", 1'b0, 64'h8000_1000, 64'd0, 8'h00, 64'd0, 1'b1);
    txn("st_above", 1'b1, 64'h8000_1000, 64'h5555_5555_5555_5555, 8'hFF, 64'd0, 1'b1);
    txn("ld_last", 1'b0, 64'h8000_0FF8, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    txn("ld_word0", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

    // response backpressure with ignored request pulses
    exp_q.push_back(64'h1122_3344_AAAA_AAAA);
    send(1'b0, 64'h8000_0008, 64'd0, 8'h00);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd2);
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = c[0] ? 1'b0 : 1'b1;
      bus.req_we    = 1'b1;
      bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.req_wmask = 8'hFF;
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_rdata", bus.rsp_rdata, 64'h1122_3344_AAAA_AAAA);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;
    finish_rsp("bp", 1'b0);
    txn("ld_after_bp", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // reset during WAIT after an accepted store
    send(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    check("mid_state_wait", 64'(dbg_state), 64'(WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) vcount++;
    end
    check("mid_rst_no_rsp", 64'(vcount), 64'd0);
    txn("ld_after_rst", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);

    // LATENCY=1: back-to-back stores, then loads, with rsp_ready tied high
    k = 0;
    rdy_pat = '0;
    vld_pat = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy_pat[c] = bus1.req_ready;
      vld_pat[c] = bus1.rsp_valid;
      if (bus1.req_ready) begin
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_wmask = 8'hFF;
        bus1.req_addr  = BASE + 64'(8 * k);
        bus1.req_wdata = 64'hC0DE_0000_0000_0000 | 64'(k);
        k++;
      end
    end
    bus1.req_valid = 1'b0;
    check("l1_st_ready_pattern", 64'(rdy_pat), 64'h155);
    check("l1_st_valid_pattern", 64'(vld_pat), 64'h2AA);
    check("l1_st_count", 64'(k), 64'd5);

    k = 0;
    rdy_pat = '0;
    vld_pat = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy_pat[c] = bus1.req_ready;
      vld_pat[c] = bus1.rsp_valid;
      if (bus1.rsp_valid && exp_q.size() > 0) begin
        check("l1_ld_rdata", bus1.rsp_rdata, exp_q.pop_front());
        check("l1_ld_err", 64'(bus1.rsp_err), 64'd0);
      end
      if (bus1.req_ready) begin
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = BASE + 64'(8 * k);
        exp_q.push_back(64'hC0DE_0000_0000_0000 | 64'(k));
        k++;
      end
    end
    bus1.req_valid = 1'b0;
    check("l1_ld_ready_pattern", 64'(rdy_pat), 64'h155);
    check("l1_ld_valid_pattern", 64'(vld_pat), 64'h2AA);
    check("l1_ld_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0000_0000_8000_0000, first byte address served.
REQ-002 Parameter DEPTH, default 512, number of 64-bit words stored.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  64  byte address; bits [2:0] ignored (word access).
REQ-010 req_wdata  input  64  store data.
REQ-011 req_wmask  input  8  byte enables for stores; bit i enables byte i (bits [8i+7:8i]).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts response.
REQ-014 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  address outside served range.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance = req_valid & req_ready at a rising edge; request fields captured then; IDLE -> WAIT with latency counter loaded to LATENCY-1.
REQ-018 WAIT: counter decrements each cycle; at counter==0 transition to RESP; with LATENCY=1 transition is IDLE -> RESP directly.
REQ-019 rsp_valid SHALL rise exactly LATENCY cycles after the acceptance edge and stay high with stable rsp_rdata/rsp_err until rsp_valid & rsp_ready.
REQ-020 Response handshake in RESP -> IDLE next cycle; no new request accepted in the handshake cycle (one outstanding request maximum).
REQ-021 In-range: BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH; word index = (addr - BASE_ADDR) >> 3, computed at full 64-bit width (no wrap).
REQ-022 Stores commit at the acceptance edge: only bytes with mask bit 1 change; wmask 8'h00 is a legal no-op store that still responds.
REQ-023 Loads sample the full 64-bit word at the acceptance edge; wmask ignored for loads.
REQ-024 Out-of-range request: no array write, rsp_rdata=0, rsp_err=1; otherwise rsp_err=0.
REQ-025 A load following a store to the same word SHALL return post-store data.
REQ-026 Request inputs while req_ready=0 SHALL be ignored.

Reset
REQ-027 rst_n low: FSM -> IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0 immediately (asynchronous); req_ready 1 after first edge with rst_n high.
REQ-028 Reset mid-WAIT/RESP aborts the transaction with no response; a store already accepted remains committed.
REQ-029 Storage array contents SHALL NOT be cleared by reset.

Structure
REQ-030 Shared package holds state enum (IDLE/WAIT/RESP), default BASE_ADDR, word/mask width constants.
REQ-031 Storage in sub-module dmem_array: one synchronous write port with byte mask, one read port, DEPTH words, no reset.
REQ-032 Control FSM, counter, range check and response registers reside in dmem_responder.

Verification
REQ-033 Reset, store addr 8000_0008 data 1122334455667788 mask FF, then load 8000_0008 -> rsp_rdata 1122334455667788, rsp_err 0, rsp_valid exactly 2 cycles after each acceptance.
REQ-034 Store 8000_0008 data AAAAAAAAAAAAAAAA mask 0F, load -> 11223344AAAAAAAA; load 8000_000C -> same word (low bits ignored).
REQ-035 Load 7FFF_FFF8 and 8000_1000 (DEPTH=512) -> rsp_err 1, rsp_rdata 0; following in-range load unaffected.
REQ-036 Hold rsp_ready 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0; req_valid pulses ignored; release -> IDLE next cycle.
REQ-037 LATENCY=1 instance: back-to-back requests accepted every 2 cycles with rsp_ready tied 1.
REQ-038 Assert rst_n low during WAIT after a store -> rsp_valid 0 immediately, no response after release; later load returns stored data.
